// File: rtl/nested_sqrt_pipe_pkg.sv
// Shared sizing helpers for the nested square-root pipeline.
// Optional checks in the other files: NESTED_SQRT_PIPE_ASSERT_EN.
package nested_sqrt_pipe_pkg;

    function automatic int res_w(input int w);
        return (w + 2) / 2;
    endfunction

    function automatic int arg_fifo_depth(input int k, input int n, input int lat);
        return (n - 1 - k) * lat;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_OUT_DEPTH = 16;
    localparam int DEF_CNT_W     = cnt_w(DEF_OUT_DEPTH);

endpackage

// File: rtl/nested_sqrt_pipe_bp_ff_fifo.sv
// Flip-flop FIFO; full-with-pop accepts a write in the same cycle.
// Optional checks: NESTED_SQRT_PIPE_ASSERT_EN (overflow / underflow).
module ff_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

`ifdef NESTED_SQRT_PIPE_ASSERT_EN
    // a push into a full FIFO without a pop, or a pop from empty, is a bug
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full && !pop)) else $error("ff_fifo overflow");
            assert (!(pop && empty)) else $error("ff_fifo underflow");
        end
    end
`endif

endmodule

// File: rtl/nested_sqrt_pipe_bp_isqrt_pipe.sv
// Non-stalling integer square root, fixed LATENCY cycles.
// Optional checks: none here (NESTED_SQRT_PIPE_ASSERT_EN unused).
module isqrt_pipe #(
    parameter int OP_W    = 16,
    parameter int LATENCY = 4,
    localparam int RW     = (OP_W + 1) / 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [OP_W-1:0] in,
    output logic          out_vld,
    output logic [RW-1:0] out
);

    function automatic logic [RW-1:0] isqrt_f(input logic [OP_W-1:0] x);
        logic [2*RW-1:0] xx;
        logic [RW+2:0]   rem;
        logic [RW+2:0]   trial;
        logic [RW-1:0]   root;
        logic            ge;
        xx   = (2*RW)'(x);
        rem  = '0;
        root = '0;
        for (int i = 0; i < RW; i++) begin
            rem   = {rem[RW:0], xx[2*RW-1 -: 2]};
            xx    = xx << 2;
            trial = (RW+3)'({root, 2'b01});
            ge    = (rem >= trial);
            if (ge) rem = rem - trial;
            root  = (root << 1) | RW'(ge);
        end
        return root;
    endfunction

    logic [LATENCY-1:0] vld_q;
    logic [RW-1:0]      dat_q [LATENCY];

    // root is formed on entry, then carried down a delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            dat_q[0] <= isqrt_f(in);
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LATENCY-1];
    assign out     = dat_q[LATENCY-1];

endmodule

// File: rtl/nested_sqrt_pipe_bp.sv
// Nested isqrt pipeline with credit-gated output FIFO backpressure.
// Optional checks: NESTED_SQRT_PIPE_ASSERT_EN.
module nested_sqrt_pipe_bp
    import nested_sqrt_pipe_pkg::*;
#(
    parameter int W             = 16,
    parameter int N_ARGS        = 3,
    parameter int ISQRT_LATENCY = 4,
    parameter int OUT_DEPTH     = 16,
    localparam int RES_W        = res_w(W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arg_vld,
    output logic                arg_rdy,
    input  logic [N_ARGS*W-1:0] arg,
    output logic                res_vld,
    input  logic                res_rdy,
    output logic [RES_W-1:0]    res
);

    localparam int CW = cnt_w(OUT_DEPTH);
    localparam int SW = W + 1;
    localparam int TW = (W + 1) / 2;

    logic             accept;
    logic             xfer;
    logic [CW-1:0]    cnt;
    logic [N_ARGS-1:0] r_vld;
    logic [RES_W-1:0] r [N_ARGS];
    logic [N_ARGS-1:0] arg_empty_unused;
    logic [RES_W-1:0] head;
    logic             out_empty;

    assign arg_rdy = rst_n && (cnt < CW'(OUT_DEPTH));
    assign accept  = arg_vld && arg_rdy;
    assign xfer    = res_vld && res_rdy;

    for (genvar k = 0; k < N_ARGS; k++) begin : g_stage
        if (k == N_ARGS - 1) begin : g_top
            logic [TW-1:0] q;
            isqrt_pipe #(
                .OP_W   (W),
                .LATENCY(ISQRT_LATENCY)
            ) u_isqrt (
                .clk    (clk),
                .rst_n  (rst_n),
                .in_vld (accept),
                .in     (arg[k*W +: W]),
                .out_vld(r_vld[k]),
                .out    (q)
            );
            assign r[k] = RES_W'(q);
            assign arg_empty_unused[k] = 1'b1;
        end else begin : g_mid
            logic [W-1:0]     a_head;
            logic [SW-1:0]    sum;
            logic [RES_W-1:0] q;
            ff_fifo #(
                .DW   (W),
                .DEPTH(arg_fifo_depth(k, N_ARGS, ISQRT_LATENCY))
            ) u_arg_fifo (
                .clk  (clk),
                .rst_n(rst_n),
                .push (accept),
                .din  (arg[k*W +: W]),
                .pop  (r_vld[k+1]),
                .dout (a_head),
                .empty(arg_empty_unused[k])
            );
            assign sum = SW'(a_head) + SW'(r[k+1]);
            isqrt_pipe #(
                .OP_W   (SW),
                .LATENCY(ISQRT_LATENCY)
            ) u_isqrt (
                .clk    (clk),
                .rst_n  (rst_n),
                .in_vld (r_vld[k+1]),
                .in     (sum),
                .out_vld(r_vld[k]),
                .out    (q)
            );
            assign r[k] = q;
        end
    end

    ff_fifo #(
        .DW   (RES_W),
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (r_vld[0]),
        .din  (r[0]),
        .pop  (xfer),
        .dout (head),
        .empty(out_empty)
    );

    assign res_vld = !out_empty;
    assign res     = res_vld ? head : '0;

    // credits: one per result in flight or parked in the output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (accept && !xfer)
            cnt <= cnt + CW'(1);
        else if (!accept && xfer)
            cnt <= cnt - CW'(1);
    end

`ifdef NESTED_SQRT_PIPE_ASSERT_EN
    logic             hold_q;
    logic [RES_W-1:0] res_q;

    // remember whether the last cycle was a stalled output
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            res_q  <= '0;
        end else begin
            hold_q <= res_vld && !res_rdy;
            res_q  <= res;
        end
    end

    // credit range and stalled-output stability
    always @(negedge clk) begin
        if (rst_n) begin
            assert (cnt <= CW'(OUT_DEPTH)) else $error("cnt out of range");
            if (hold_q)
                assert (res == res_q) else $error("res changed while stalled");
        end
    end
`endif

endmodule

// File: tb/tb_nested_sqrt_pipe_bp.sv
// Directed + random bench for nested_sqrt_pipe_bp, scoreboard checked.
// Defaults: W=16, N_ARGS=3, ISQRT_LATENCY=4, OUT_DEPTH=16 (L=13).
module tb_nested_sqrt_pipe_bp;

    localparam int W         = 16;
    localparam int N_ARGS    = 3;
    localparam int ISQ_LAT   = 4;
    localparam int OUT_DEPTH = 16;
    localparam int RES_W     = (W + 2) / 2;
    localparam int LAT       = N_ARGS * ISQ_LAT + 1;

    logic                clk;
    logic                rst_n;
    logic                arg_vld;
    logic                arg_rdy;
    logic [N_ARGS*W-1:0] arg;
    logic                res_vld;
    logic                res_rdy;
    logic [RES_W-1:0]    res;

    nested_sqrt_pipe_bp #(
        .W            (W),
        .N_ARGS       (N_ARGS),
        .ISQRT_LATENCY(ISQ_LAT),
        .OUT_DEPTH    (OUT_DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arg_vld(arg_vld),
        .arg_rdy(arg_rdy),
        .arg    (arg),
        .res_vld(res_vld),
        .res_rdy(res_rdy),
        .res    (res)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int last_acc_cyc = 0;
    int last_out_cyc = 0;
    int mark_idx = -1;
    int mark_cyc = 0;
    int unsigned q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned isqrt_m(input int unsigned x);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int unsigned model(input logic [N_ARGS*W-1:0] v);
        int unsigned r;
        r = isqrt_m(v[(N_ARGS-1)*W +: W]);
        for (int k = N_ARGS - 2; k >= 0; k--)
            r = isqrt_m(v[k*W +: W] + r);
        return r;
    endfunction

    function automatic logic [N_ARGS*W-1:0] rand_arg();
        logic [N_ARGS*W-1:0] v;
        for (int k = 0; k < N_ARGS; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    // scoreboard: pop on output transfer, push on accept
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_vld && res_rdy) begin
                check("out_expected", q.size() != 0, 1);
                if (q.size() != 0) check("res_value", res, q.pop_front());
                if (n_out == mark_idx) mark_cyc = cyc;
                last_out_cyc = cyc;
                n_out++;
            end
            if (arg_vld && arg_rdy) begin
                q.push_back(model(arg));
                last_acc_cyc = cyc;
                n_acc++;
            end
            check("credit", q.size() <= OUT_DEPTH, 1);
        end
    end

    task automatic send(input logic [N_ARGS*W-1:0] v);
        int w = 0;
        arg = v;
        arg_vld = 1'b1;
        @(negedge clk);
        while (!arg_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("send_rdy", arg_rdy, 1);
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q.size() != 0 || res_vld); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", q.size(), 0);
    endtask

    task automatic lat_test(input string tag, input int unsigned exp_val);
        int acc;
        bit seen = 0;
        acc = last_acc_cyc;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (res_vld) seen = 1;
        end
        check({tag, "_seen"}, seen, 1);
        check({tag, "_lat"}, cyc - acc, LAT);
        check({tag, "_val"}, res, exp_val);
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        int a0;
        int sent;
        int guard;
        int stale;
        logic [RES_W-1:0] hold;

        rst_n = 1'b0;
        arg_vld = 1'b0;
        arg = '0;
        res_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arg_rdy", arg_rdy, 0);
        check("rst_res_vld", res_vld, 0);
        check("rst_res", res, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", arg_rdy, 1);
        @(posedge clk);
        #1;

        send({16'd81, 16'd7, 16'd12});
        lat_test("v12_7_81", 4);
        send({16'd0, 16'd0, 16'd0});
        lat_test("v0", 0);
        send({16'hFFFF, 16'hFFFF, 16'hFFFF});
        lat_test("vmax", 256);

        mark_idx = n_out;
        for (int i = 0; i < 100; i++) begin
            arg = rand_arg();
            arg_vld = 1'b1;
            @(negedge clk);
            check("tp_rdy", arg_rdy, 1);
            @(posedge clk);
            #1;
        end
        arg_vld = 1'b0;
        drain();
        check("tp_count", n_out - mark_idx, 100);
        check("tp_rate", last_out_cyc - mark_cyc, 99);
        mark_idx = -1;

        res_rdy = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 30; i++) begin
            arg = rand_arg();
            arg_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        arg_vld = 1'b0;
        check("bp_accepts", n_acc - a0, OUT_DEPTH);
        check("bp_rdy_low", arg_rdy, 0);
        @(negedge clk);
        hold = res;
        check("bp_vld", res_vld, 1);
        repeat (3) @(negedge clk);
        check("bp_hold", res, hold);
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        @(negedge clk);
        check("bp_rdy_still_low", arg_rdy, 0);
        @(negedge clk);
        check("bp_rdy_back", arg_rdy, 1);
        @(posedge clk);
        #1;
        drain();

        sent = 0;
        guard = 0;
        a0 = n_out;
        while (sent < 1000 && guard < 20000) begin
            arg_vld = 1'($urandom_range(0, 1));
            arg = rand_arg();
            res_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (arg_vld && arg_rdy) sent++;
            @(posedge clk);
            #1;
            guard++;
        end
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        check("rnd_sent", sent, 1000);
        drain();
        check("rnd_count", n_out - a0, 1000);

        for (int i = 0; i < 10; i++) send(rand_arg());
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", res_vld, 0);
        check("mid_rst_rdy", arg_rdy, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_vld) stale++;
        end
        check("no_stale", stale, 0);
        @(posedge clk);
        #1;
        send({16'd81, 16'd7, 16'd12});
        lat_test("post_rst", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
